// File: rtl/aes_inv_pkg.sv
// Shared AES-128 tables and arithmetic for the iterative decryption core:
// S-boxes, round constants, GF(2^8) helpers and forward/backward key steps.
package aes_inv_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[2047 - 8*int'(a) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return INV_SBOX_TBL[2047 - 8*int'(a) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // SubWord(RotWord(w)) xor the round constant in the top byte
  function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_core(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Previous round key recovered from the current one; rc is the constant
  // that produced the current key.
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ key_core(p3, rc);
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
module aes_inv_round import aes_inv_pkg::*; (
  input  logic [127:0] st,
  input  logic [127:0] rkp,
  input  logic         last,
  output logic [127:0] nxt
);

  logic [127:0] sub;
  logic [127:0] t;
  logic [127:0] mc;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Byte r of column c comes from column (c - r) mod 4 of the input
  always_comb begin
    sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[127 - 8*(r + 4*c) -: 8] = inv_sbox(st[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
      end
    end
  end

  assign t = sub ^ rkp;

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = inv_mix_col(t[127 - 32*c -: 32]);
    end
  end

  assign nxt = last ? t : mc;

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: forward key expansion, then one inverse round
// per clock with the key schedule run backwards. Optional AES_INV_KEY_CACHE_EN.
module aes_inv_top import aes_inv_pkg::*; (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] din_r;
  logic [127:0] rk;
  logic [127:0] st;
  logic [127:0] rk_fwd;
  logic [127:0] rkp;
  logic [127:0] nxt;

  assign rk_fwd = fwd_key_step(rk, rcon(cnt));
  assign rkp    = inv_key_step(rk, rcon(cnt));

  aes_inv_round u_round (
    .st   (st),
    .rkp  (rkp),
    .last (cnt == 4'd1),
    .nxt  (nxt)
  );

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] key_last;
  logic [127:0] rk10_c;
  logic         cache_vld;
  logic         cache_hit;

  assign cache_hit = cache_vld && (AES_key_in == key_last);
`endif

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state              <= IDLE;
      cnt                <= '0;
      din_r              <= '0;
      rk                 <= '0;
      st                 <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
      key_last           <= '0;
      rk10_c             <= '0;
      cache_vld          <= 1'b0;
`endif
    end else begin
      AES_data_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (AES_en) begin
            din_r <= AES_data_in;
            rk    <= AES_key_in;
            cnt   <= 4'd1;
            state <= KEXP;
`ifdef AES_INV_KEY_CACHE_EN
            // The key is remembered now; the entry only becomes usable once
            // its rk10 is written at the end of expansion.
            key_last  <= AES_key_in;
            cache_vld <= 1'b0;
            if (cache_hit) begin
              st        <= AES_data_in ^ rk10_c;
              rk        <= rk10_c;
              cnt       <= 4'd10;
              state     <= ROUND;
              cache_vld <= 1'b1;
            end
`endif
          end
        end
        KEXP: begin
          rk <= rk_fwd;
          if (cnt == 4'd10) begin
            st    <= din_r ^ rk_fwd;
            state <= ROUND;
`ifdef AES_INV_KEY_CACHE_EN
            rk10_c    <= rk_fwd;
            cache_vld <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          if (cnt == 4'd1) begin
            AES_data_out       <= nxt;
            AES_data_out_valid <= 1'b1;
            state              <= IDLE;
            cnt                <= '0;
          end else begin
            st  <= nxt;
            rk  <= rkp;
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
